// File: rtl/shift_frame_sync.sv
// shift_frame_sync
//   Frame synchroniser placed after an 8-bit serial-in shift register.
//   Hunts for the SYNC byte at every shift.  Once locked, it cuts the serial
//   stream into bytes, one byte per 8 shifts, and checks that a sync byte
//   follows every frame of FRAME_LEN data bytes.  Lock is dropped after
//   MAX_MISS consecutive missing sync bytes.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-high reset
//   q_in[7:0]  : parallel shift register output, bit 0 = newest serial bit
//   shift_en   : q_in holds a freshly shifted value this cycle
//   byte_out   : last captured data byte, held until the next capture
//   byte_valid : one-cycle pulse, byte_out is new
//   locked     : state is DATA or CHECK
//   frame_done : one-cycle pulse with the last data byte of a frame
//   sync_err   : one-cycle pulse when the expected sync byte is missing
//   miss_cnt   : consecutive missed sync bytes
module shift_frame_sync #(
    parameter logic [7:0] SYNC      = 8'hA5,
    parameter int         FRAME_LEN = 4,
    parameter int         MAX_MISS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] q_in,
    input  logic       shift_en,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       locked,
    output logic       frame_done,
    output logic       sync_err,
    output logic [1:0] miss_cnt
);

    localparam logic [1:0] HUNT  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);
    localparam logic [2:0] MISS_LIM  = 3'(MAX_MISS);

    logic [1:0] state, nxt_state;
    logic [2:0] bit_cnt, nxt_bit;
    logic [7:0] byte_cnt, nxt_byte;
    logic [1:0] nxt_miss;
    logic [7:0] nxt_out;
    logic       nxt_valid, nxt_done, nxt_err;

    always_comb begin
        nxt_state = state;
        nxt_bit   = bit_cnt;
        nxt_byte  = byte_cnt;
        nxt_miss  = miss_cnt;
        nxt_out   = byte_out;
        nxt_valid = 1'b0;
        nxt_done  = 1'b0;
        nxt_err   = 1'b0;
        if (shift_en) begin
            case (state)
                HUNT: begin
                    // bit-level search: every shift is a candidate alignment
                    if (q_in == SYNC) begin
                        nxt_state = DATA;
                        nxt_bit   = 3'd0;
                        nxt_byte  = 8'd0;
                    end
                end
                DATA: begin
                    nxt_bit = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        nxt_out   = q_in;
                        nxt_valid = 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            nxt_byte  = 8'd0;
                            nxt_done  = 1'b1;
                            nxt_state = CHECK;
                        end else begin
                            nxt_byte = byte_cnt + 8'd1;
                        end
                    end
                end
                CHECK: begin
                    nxt_bit = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (q_in == SYNC) begin
                            nxt_miss  = 2'd0;
                            nxt_state = DATA;
                        end else begin
                            nxt_err = 1'b1;
                            if (({1'b0, miss_cnt} + 3'd1) == MISS_LIM) begin
                                nxt_miss  = 2'd0;
                                nxt_state = HUNT;
                            end else begin
                                // flywheel: treat the missed slot as a sync slot
                                nxt_miss  = miss_cnt + 2'd1;
                                nxt_state = DATA;
                            end
                        end
                    end
                end
                default: nxt_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 8'd0;
            miss_cnt   <= 2'd0;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= nxt_state;
            bit_cnt    <= nxt_bit;
            byte_cnt   <= nxt_byte;
            miss_cnt   <= nxt_miss;
            byte_out   <= nxt_out;
            byte_valid <= nxt_valid;
            // registered copy of the state decode so locked tracks state exactly
            locked     <= (nxt_state != HUNT);
            frame_done <= nxt_done;
            sync_err   <= nxt_err;
        end
    end

endmodule
